// File: rtl/rv32i_pkg.sv
// RV32I field constants shared by the instruction encoder and decoder.
package rv32i_pkg;

  localparam logic [7:0] ALUOP_NOP  = 8'h00;
  localparam logic [7:0] ALUOP_ADD  = 8'h01;
  localparam logic [7:0] ALUOP_SUB  = 8'h02;
  localparam logic [7:0] ALUOP_SLL  = 8'h03;
  localparam logic [7:0] ALUOP_SLT  = 8'h04;
  localparam logic [7:0] ALUOP_SLTU = 8'h05;
  localparam logic [7:0] ALUOP_XOR  = 8'h06;
  localparam logic [7:0] ALUOP_SRL  = 8'h07;
  localparam logic [7:0] ALUOP_SRA  = 8'h08;
  localparam logic [7:0] ALUOP_OR   = 8'h09;
  localparam logic [7:0] ALUOP_AND  = 8'h0a;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [2:0] funct3_of(input logic [7:0] aluop);
    case (aluop)
      ALUOP_SLL:            return F3_SLL;
      ALUOP_SLT:            return F3_SLT;
      ALUOP_SLTU:           return F3_SLTU;
      ALUOP_XOR:            return F3_XOR;
      ALUOP_SRL, ALUOP_SRA: return F3_SRL_SRA;
      ALUOP_OR:             return F3_OR;
      ALUOP_AND:            return F3_AND;
      default:              return F3_ADD_SUB;
    endcase
  endfunction

  function automatic logic is_shift(input logic [7:0] aluop);
    return (aluop == ALUOP_SLL) || (aluop == ALUOP_SRL) || (aluop == ALUOP_SRA);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; rd_data reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr, do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs ALU requests into RV32I R/I-type words and streams them with byte addresses.
// INSTR_ENCODER_ILLEGAL_NOP_EN: illegal requests enqueue a NOP instead of being dropped.
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_aluop,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_imm_enable,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_illegal,
  output logic [7:0]  err_count
);
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        shift_op, illegal, accept, push, pop, full, empty;
  logic [31:0] enc_instr, fifo_din;

  always_comb begin
    f3        = funct3_of(in_aluop);
    f7        = ((in_aluop == ALUOP_SUB) || (in_aluop == ALUOP_SRA)) ? F7_ALT : F7_BASE;
    shift_op  = is_shift(in_aluop);
    illegal   = 1'b0;
    enc_instr = {f7, in_rs2, in_rs1, f3, in_rd, OPC_OP};
    if ((in_aluop == ALUOP_NOP) || (in_aluop > ALUOP_AND)) begin
      illegal = 1'b1;
    end else if (in_imm_enable) begin
      if (in_aluop == ALUOP_SUB) illegal = 1'b1;
      else if (shift_op)         illegal = |in_imm[31:5];
      else                       illegal = !((&in_imm[31:11]) || !(|in_imm[31:11]));
    end
    if (in_imm_enable) begin
      if (shift_op) enc_instr = {f7, in_imm[4:0], in_rs1, f3, in_rd, OPC_OPIMM};
      else          enc_instr = {in_imm[11:0], in_rs1, f3, in_rd, OPC_OPIMM};
    end
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

`ifdef INSTR_ENCODER_ILLEGAL_NOP_EN
  assign push     = accept;
  assign fifo_din = illegal ? NOP_INSTR : enc_instr;
`else
  assign push     = accept && !illegal;
  assign fifo_din = enc_instr;
`endif

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (fifo_din),
    .rd_en   (pop),
    .rd_data (out_instr),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr    <= BASE_ADDR;
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else if (flush) begin
      out_addr    <= BASE_ADDR;
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      if (pop) out_addr <= out_addr + 32'd4;
      if (accept && illegal) begin
        err_illegal <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-encoded RV32I words.
module tb_instr_encoder;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_imm_enable;
  logic [7:0]  in_aluop;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, err_illegal;
  logic [31:0] out_instr, out_addr;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_imm_enable(in_imm_enable),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_illegal(err_illegal), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [7:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic ie);
    in_aluop = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_imm_enable = ie;
  endtask

  task automatic push(input logic [7:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic ie);
    set_req(op, rd, rs1, rs2, imm, ie);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_addr += 32'd4;
  endtask

  // add x1,x2,x3 / sub x4,x5,x6 / xor x7,x8,x9 / andi x10,x11,0x7ff
  logic [7:0]  bp_op   [4] = '{8'h01, 8'h02, 8'h06, 8'h0a};
  logic [4:0]  bp_rd   [4] = '{5'd1, 5'd4, 5'd7, 5'd10};
  logic [4:0]  bp_rs1  [4] = '{5'd2, 5'd5, 5'd8, 5'd11};
  logic [4:0]  bp_rs2  [4] = '{5'd3, 5'd6, 5'd9, 5'd0};
  logic [31:0] bp_imm  [4] = '{32'd0, 32'd0, 32'd0, 32'h7FF};
  logic        bp_ie   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] bp_exp  [4] = '{32'h003100B3, 32'h40628233, 32'h009443B3, 32'h7FF5F513};

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(8'h00, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    exp_addr = 32'h0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_err_illegal", {31'd0, err_illegal}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);

    push(8'h01, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_instr", out_instr, 32'h002081B3);
    check("add_addr", out_addr, exp_addr);
    pop_one();
    check("add_popped", {31'd0, out_valid}, 32'd0);
    check("add_addr_inc", out_addr, exp_addr);

    push(8'h01, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    check("addi_instr", out_instr, 32'hFFF00293);
    check("addi_addr", out_addr, exp_addr);
    pop_one();

    push(8'h08, 5'd1, 5'd1, 5'd0, 32'd3, 1'b1);
    check("srai_instr", out_instr, 32'h4030D093);
    check("srai_addr", out_addr, exp_addr);
    pop_one();

    push(8'h02, 5'd1, 5'd1, 5'd0, 32'd5, 1'b1);
    check("subi_err", {31'd0, err_illegal}, 32'd1);
    check("subi_count", {24'd0, err_count}, 32'd1);
`ifdef INSTR_ENCODER_ILLEGAL_NOP_EN
    check("subi_nop", out_instr, 32'h00000013);
    check("subi_nop_addr", out_addr, exp_addr);
    pop_one();
`else
    check("subi_dropped", {31'd0, out_valid}, 32'd0);
`endif

    push(8'h03, 5'd1, 5'd1, 5'd0, 32'd32, 1'b1);
    check("shamt_count", {24'd0, err_count}, 32'd2);
`ifdef INSTR_ENCODER_ILLEGAL_NOP_EN
    pop_one();
`else
    check("shamt_dropped", {31'd0, out_valid}, 32'd0);
`endif

    // back-pressure: fill, then drain in order
    for (int i = 0; i < 4; i++) begin
      set_req(bp_op[i], bp_rd[i], bp_rs1[i], bp_rs2[i], bp_imm[i], bp_ie[i]);
      in_valid = 1'b1;
      check("bp_ready_fill", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check("bp_full", {31'd0, in_ready}, 32'd0);
    check("bp_hold_instr", out_instr, bp_exp[0]);
    out_ready = 1'b1;
    check("bp_ready_count_only", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_instr", out_instr, bp_exp[i]);
      check("bp_addr", out_addr, exp_addr);
      tick();
      exp_addr += 32'd4;
    end
    out_ready = 1'b0;
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    check("bp_ready_again", {31'd0, in_ready}, 32'd1);

    // streaming push+pop each cycle
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(bp_op[i], bp_rd[i], bp_rs1[i], bp_rs2[i], bp_imm[i], bp_ie[i]);
      in_valid = 1'b1;
      tick();
      check("stream_instr", out_instr, bp_exp[i]);
      check("stream_addr", out_addr, exp_addr);
      exp_addr += 32'd4;
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("stream_empty", {31'd0, out_valid}, 32'd0);
    check("stream_addr_end", out_addr, exp_addr);

    // flush with two queued and a simultaneous push
    push(8'h01, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    push(8'h06, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0);
    set_req(8'h0a, 5'd10, 5'd11, 5'd0, 32'h7FF, 1'b1);
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    exp_addr = 32'h0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_err", {31'd0, err_illegal}, 32'd0);
    check("flush_count", {24'd0, err_count}, 32'd0);
    check("flush_addr", out_addr, exp_addr);
    tick();
    check("flush_push_discarded", {31'd0, out_valid}, 32'd0);
    push(8'h01, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    check("post_flush_instr", out_instr, 32'hFFF00293);
    check("post_flush_addr", out_addr, 32'h0);

    // error counter saturation
    out_ready = 1'b1;
    set_req(8'h0b, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    in_valid = 1'b1;
    repeat (260) tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("sat_count", {24'd0, err_count}, 32'd255);
    check("sat_err", {31'd0, err_illegal}, 32'd1);

    // reset mid-stream
    push(8'h01, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    check("mid_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_instr", out_instr, 32'h0);
    check("mid_rst_addr", out_addr, 32'h0);
    check("mid_rst_count", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_empty", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
